// File: rtl/mem_access_unit.sv
// Memory stage: drives a single-port data-cache handshake for RV32I loads/stores,
// aligns store lanes, extends load data and passes non-memory results to writeback.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [4:0]        in_rd,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_mbe,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              out_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state, state_n;
    logic              dmem_read_n, dmem_write_n;
    logic [ADDR_W-1:0] dmem_address_n;
    logic [DATA_W-1:0] dmem_wdata_n;
    logic [3:0]        dmem_mbe_n;
    logic              out_valid_n, out_we_n, out_misaligned_n;
    logic [DATA_W-1:0] out_data_n;
    logic [4:0]        out_rd_n;

    // Context of the in-flight memory op, used to finish it on dmem_resp
    logic              op_load, op_load_n;
    logic [2:0]        op_funct3, op_funct3_n;
    logic [1:0]        op_off, op_off_n;
    logic [4:0]        op_rd, op_rd_n;

    logic              accept, is_mem, misaligned;
    logic [1:0]        off;
    logic [DATA_W-1:0] shifted, load_ext;

    assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign is_mem     = in_is_load || in_is_store;
    assign off        = in_alu_out[1:0];
    // funct3[1:0]: 00 byte, 01 half, anything else is handled as a word
    assign misaligned = (in_funct3[1:0] == 2'b01) ? off[0] :
                        (in_funct3[1:0] == 2'b00) ? 1'b0 : (off != 2'b00);

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        shifted = dmem_rdata >> {op_off, 3'b000};
        case (op_funct3[1:0])
            2'b00:   load_ext = op_funct3[2] ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = op_funct3[2] ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_n          = state;
        dmem_read_n      = dmem_read;
        dmem_write_n     = dmem_write;
        dmem_address_n   = dmem_address;
        dmem_wdata_n     = dmem_wdata;
        dmem_mbe_n       = dmem_mbe;
        out_valid_n      = out_valid;
        out_data_n       = out_data;
        out_rd_n         = out_rd;
        out_we_n         = out_we;
        out_misaligned_n = out_misaligned;
        op_load_n        = op_load;
        op_funct3_n      = op_funct3;
        op_off_n         = op_off;
        op_rd_n          = op_rd;

        case (state)
            REQ: begin
                if (dmem_resp) begin
                    state_n      = DONE;
                    dmem_read_n  = 1'b0;
                    dmem_write_n = 1'b0;
                    out_valid_n  = 1'b1;
                    out_data_n   = op_load ? load_ext : '0;
                    out_rd_n     = op_load ? op_rd : 5'd0;
                    out_we_n     = op_load && (op_rd != 5'd0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                end
            end
            default: ;
        endcase

        // A new op from IDLE, or back-to-back from DONE, overrides the above
        if (accept) begin
            out_valid_n      = 1'b0;
            out_misaligned_n = 1'b0;
            dmem_read_n      = 1'b0;
            dmem_write_n     = 1'b0;
            if (!is_mem) begin
                state_n     = DONE;
                out_valid_n = 1'b1;
                out_data_n  = in_alu_out;
                out_rd_n    = in_rd;
                out_we_n    = (in_rd != 5'd0);
            end else if (misaligned) begin
                state_n          = DONE;
                out_valid_n      = 1'b1;
                out_misaligned_n = 1'b1;
                out_data_n       = '0;
                out_rd_n         = in_is_store ? 5'd0 : in_rd;
                out_we_n         = 1'b0;
            end else begin
                state_n        = REQ;
                dmem_read_n    = in_is_load;
                dmem_write_n   = in_is_store;
                dmem_address_n = ADDR_W'(in_alu_out) & ~ADDR_W'(3);
                out_we_n       = 1'b0;
                op_load_n      = in_is_load;
                op_funct3_n    = in_funct3;
                op_off_n       = off;
                op_rd_n        = in_rd;
                if (in_is_load) begin
                    dmem_mbe_n   = 4'b1111;
                    dmem_wdata_n = in_store_data;
                end else begin
                    case (in_funct3[1:0])
                        2'b00: begin
                            dmem_mbe_n   = 4'b0001 << off;
                            dmem_wdata_n = {4{in_store_data[7:0]}};
                        end
                        2'b01: begin
                            dmem_mbe_n   = 4'b0011 << off;
                            dmem_wdata_n = {2{in_store_data[15:0]}};
                        end
                        default: begin
                            dmem_mbe_n   = 4'b1111;
                            dmem_wdata_n = in_store_data;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            dmem_read      <= 1'b0;
            dmem_write     <= 1'b0;
            dmem_address   <= '0;
            dmem_wdata     <= '0;
            dmem_mbe       <= 4'b0000;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_rd         <= 5'd0;
            out_we         <= 1'b0;
            out_misaligned <= 1'b0;
            op_load        <= 1'b0;
            op_funct3      <= 3'd0;
            op_off         <= 2'd0;
            op_rd          <= 5'd0;
        end else begin
            state          <= state_n;
            dmem_read      <= dmem_read_n;
            dmem_write     <= dmem_write_n;
            dmem_address   <= dmem_address_n;
            dmem_wdata     <= dmem_wdata_n;
            dmem_mbe       <= dmem_mbe_n;
            out_valid      <= out_valid_n;
            out_data       <= out_data_n;
            out_rd         <= out_rd_n;
            out_we         <= out_we_n;
            out_misaligned <= out_misaligned_n;
            op_load        <= op_load_n;
            op_funct3      <= op_funct3_n;
            op_off         <= op_off_n;
            op_rd          <= op_rd_n;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: inputs change and outputs
// are sampled on the falling edge, the DUT acts on the rising edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_out, in_store_data;
    logic [4:0]  in_rd;
    logic        dmem_read, dmem_write, dmem_resp;
    logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_mbe;
    logic        out_valid, out_ready, out_we, out_misaligned;
    logic [31:0] out_data;
    logic [4:0]  out_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_alu_out(in_alu_out),
        .in_store_data(in_store_data), .in_rd(in_rd),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_mbe(dmem_mbe), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_we(out_we), .out_misaligned(out_misaligned)
    );

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_is_load    = 1'b0;
        in_is_store   = 1'b0;
        in_funct3     = 3'b000;
        in_alu_out    = 32'h0;
        in_store_data = 32'h0;
        in_rd         = 5'd0;
        dmem_resp     = 1'b0;
        dmem_rdata    = 32'h0;
        out_ready     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_we !== 1'b0 || out_rd !== 5'd0
            || out_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b data=%h we=%b rd=%0d mis=%b, expected all zero",
                     out_valid, out_data, out_we, out_rd, out_misaligned);
        end
        n_checks++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || dmem_mbe !== 4'h0
            || dmem_address !== 32'h0 || dmem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dmem: rd=%b wr=%b mbe=%h addr=%h wdata=%h, expected all zero",
                     dmem_read, dmem_write, dmem_mbe, dmem_address, dmem_wdata);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_passthrough();
        logic [31:0] vals [3];
        logic [4:0]  rds  [3];
        vals[0] = 32'h0000_1234; rds[0] = 5'd5;
        vals[1] = 32'h0000_1111; rds[1] = 5'd6;
        vals[2] = 32'h0000_2222; rds[2] = 5'd0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'b1;
            in_alu_out = vals[i];
            in_rd      = rds[i];
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || out_rd !== rds[i]
                || out_we !== (rds[i] != 5'd0) || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL alu_pass[%0d]: valid=%b data=%h rd=%0d we=%b rdy=%b, expected 1 %h %0d %b 1",
                         i, out_valid, out_data, out_rd, out_we, in_ready,
                         vals[i], rds[i], rds[i] != 5'd0);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int waits, input logic [31:0] exp);
        int          reads = 0;
        logic [31:0] addr_seen = 32'h0;
        logic [3:0]  mbe_seen  = 4'h0;
        logic        rdy_seen  = 1'b1;
        @(negedge clk);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = f3;
        in_alu_out = addr;
        in_rd      = 5'd7;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            in_is_load = 1'b0;
            if (dmem_read === 1'b1) reads++;
            if (i == 0) begin
                addr_seen = dmem_address;
                mbe_seen  = dmem_mbe;
                rdy_seen  = in_ready;
            end
            if (i == waits - 1) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rdata;
            end
        end
        @(negedge clk);
        dmem_resp = 1'b0;
        n_checks++;
        if (reads != waits || addr_seen !== (addr & 32'hFFFF_FFFC) || mbe_seen !== 4'hF
            || rdy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_req: reads=%0d addr=%h mbe=%h rdy=%b, expected %0d %h f 0",
                     name, reads, addr_seen, mbe_seen, rdy_seen, waits, addr & 32'hFFFF_FFFC);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp || out_we !== 1'b1 || out_rd !== 5'd7
            || dmem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result: valid=%b data=%h we=%b rd=%0d dread=%b, expected 1 %h 1 7 0",
                     name, out_valid, out_data, out_we, out_rd, dmem_read, exp);
        end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [3:0] exp_mbe,
                              input logic [31:0] exp_wdata);
        @(negedge clk);
        in_valid      = 1'b1;
        in_is_store   = 1'b1;
        in_funct3     = f3;
        in_alu_out    = addr;
        in_store_data = sdata;
        in_rd         = 5'd9;
        @(negedge clk);
        in_valid    = 1'b0;
        in_is_store = 1'b0;
        n_checks++;
        if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_mbe !== exp_mbe
            || dmem_wdata !== exp_wdata || dmem_address !== (addr & 32'hFFFF_FFFC)) begin
            n_fail++;
            $display("FAIL %s_req: wr=%b rd=%b mbe=%h wdata=%h addr=%h, expected 1 0 %h %h %h",
                     name, dmem_write, dmem_read, dmem_mbe, dmem_wdata, dmem_address,
                     exp_mbe, exp_wdata, addr & 32'hFFFF_FFFC);
        end
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_we !== 1'b0 || out_rd !== 5'd0 || dmem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: valid=%b we=%b rd=%0d wr=%b, expected 1 0 0 0",
                     name, out_valid, out_we, out_rd, dmem_write);
        end
    endtask

    task automatic test_misaligned();
        int reads = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'b010;
        in_alu_out = 32'h0000_3001;
        in_rd      = 5'd3;
        @(negedge clk);
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        if (dmem_read === 1'b1) reads++;
        n_checks++;
        if (out_valid !== 1'b1 || out_misaligned !== 1'b1 || out_data !== 32'h0 || out_we !== 1'b0) begin
            n_fail++;
            $display("FAIL misaligned_result: valid=%b mis=%b data=%h we=%b, expected 1 1 0 0",
                     out_valid, out_misaligned, out_data, out_we);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dmem_read === 1'b1) reads++;
        end
        n_checks++;
        if (reads != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL misaligned_noreq: reads=%0d valid=%b, expected 0 0", reads, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'b010;
        in_alu_out = 32'h0000_4000;
        in_rd      = 5'd4;
        @(negedge clk);
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        // Offer a second op while the result is stalled
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_alu_out = 32'h0000_4004;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_rd !== 5'd4
                || out_we !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: valid=%b data=%h rd=%0d we=%b rdy=%b, expected 1 12345678 4 1 0",
                         i, out_valid, out_data, out_rd, out_we, in_ready);
            end
            @(negedge clk);
            if (dmem_read === 1'b1) reqs++;
        end
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        out_ready  = 1'b1;
        #1;
        n_checks++;
        if (reqs != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: reqs=%0d rdy=%b, expected 0 1", reqs, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_drain: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'b001;
        in_alu_out = 32'h0000_5002;
        in_rd      = 5'd2;
        @(negedge clk);
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        n_checks++;
        if (dmem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_req: dmem_read=%b expected 1", dmem_read);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dmem_read !== 1'b0 || dmem_mbe !== 4'h0) begin
            n_fail++;
            $display("FAIL abort_drop: dmem_read=%b mbe=%h, expected 0 0", dmem_read, dmem_mbe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_resp = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_late_resp: valid=%b rdy=%b data=%h, expected 0 1 0",
                     out_valid, in_ready, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_load("lb",  3'b000, 32'h0000_1003, 32'h80FF_0000, 3, 32'hFFFF_FF80);
        test_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_0000, 3, 32'h0000_0080);
        test_load("lh",  3'b001, 32'h0000_6002, 32'h8001_7FFF, 1, 32'hFFFF_8001);
        test_load("lhu", 3'b101, 32'h0000_6002, 32'h8001_7FFF, 1, 32'h0000_8001);
        test_load("lw",  3'b010, 32'h0000_6004, 32'h8001_7FFF, 2, 32'h8001_7FFF);
        test_store("sh", 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
        test_store("sb", 3'b000, 32'h0000_7001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        test_store("sw", 3'b010, 32'h0000_7004, 32'h0123_4567, 4'b1111, 32'h0123_4567);
        test_misaligned();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
